// File: rtl/dmg_lcd_capture.sv
// DMG LCD panel bus receiver: oversamples the LCD pins, tracks (x, y) from
// cp/cpl/s edges and queues tagged 2-bit pixels into a FWFT valid/ready FIFO.
module dmg_lcd_capture #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 144,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          n_res,
    input  logic                          s,
    input  logic                          cp,
    input  logic                          cpl,
    input  logic                          st,
    input  logic                          fr,
    input  logic                          ld0,
    input  logic                          ld1,
    input  logic                          clr,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [1:0]                    pix_data,
    output logic [7:0]                    pix_x,
    output logic [7:0]                    pix_y,
    output logic                          pix_sof,
    output logic                          pix_eol,
    output logic                          frame_done,
    output logic                          ovf,
    output logic                          err_len,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] W8 = 8'(WIDTH);
    localparam logic [7:0] H8 = 8'(HEIGHT);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // bit order: {ld1, ld0, fr, st, cpl, cp, s}
    logic [6:0] raw;
    logic [6:0] sync_q [SYNC_STAGES];
    logic [6:0] syn;
    logic [2:0] prev_q;
    logic       sync_unused;

    assign raw = {ld1, ld0, fr, st, cpl, cp, s};
    assign syn = sync_q[SYNC_STAGES-1];
    assign sync_unused = ^syn[4:3];

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= syn[2:0];
        end
    end

    logic s_rise, pix_ev, line_ev;
    assign s_rise  =  syn[0] & ~prev_q[0];
    assign pix_ev  = ~syn[1] &  prev_q[1];
    assign line_ev =  syn[2] & ~prev_q[2];

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic        sof_q, sof_d;
    logic        push_req, err_ev, frame_d;
    logic [19:0] push_entry;

    // s_rise, pix and line are applied in that order, each seeing the previous result
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        sof_d      = sof_q;
        push_req   = 1'b0;
        push_entry = '0;
        err_ev     = 1'b0;
        frame_d    = 1'b0;
        if (s_rise) begin
            state_d = ACTIVE;
            x_d     = '0;
            y_d     = '0;
            sof_d   = 1'b1;
        end
        if (pix_ev && state_d == ACTIVE) begin
            if (x_d < W8) begin
                push_req   = 1'b1;
                push_entry = {syn[6:5], x_d, y_d, sof_d, x_d == W8 - 8'd1};
                x_d        = x_d + 8'd1;
                sof_d      = 1'b0;
            end else begin
                err_ev = 1'b1;
            end
        end
        if (line_ev && state_d == ACTIVE) begin
            if (x_d != W8) err_ev = 1'b1;
            x_d = '0;
            y_d = y_d + 8'd1;
            if (y_d == H8) begin
                frame_d = 1'b1;
                state_d = IDLE;
                y_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            sof_q      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            sof_q      <= sof_d;
            frame_done <= frame_d;
        end
    end

    logic [19:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          pop, push, drop;
    logic [19:0]   head;

    assign pix_valid = (cnt_q != '0);
    assign pop       = pix_valid & pix_ready;
    assign push      = push_req & ((cnt_q < DEPTH_C) | pop);
    assign drop      = push_req & ~push;
    assign fill      = cnt_q;

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf     <= 1'b0;
            err_len <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            // a new error in the clr cycle wins
            ovf     <= (ovf & ~clr) | drop;
            err_len <= (err_len & ~clr) | err_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= push_entry;
    end

    // outputs read zero whenever the FIFO is empty, including straight out of reset
    assign head = pix_valid ? mem[rd_q] : '0;
    assign {pix_data, pix_x, pix_y, pix_sof, pix_eol} = head;

endmodule

// File: tb/tb_dmg_lcd_capture.sv
// Randomized directed bench for dmg_lcd_capture against a pixel-queue model
// that follows the panel rules (reduced WIDTH/HEIGHT to keep runtime short).
module tb_dmg_lcd_capture;

    localparam int W  = 40;
    localparam int H  = 12;
    localparam int D  = 8;
    localparam int SS = 2;

    typedef struct packed {
        logic [1:0] d;
        logic [7:0] x;
        logic [7:0] y;
        logic       sof;
        logic       eol;
    } ent_t;

    logic clk = 1'b0;
    logic n_res, s, cp, cpl, st, fr, ld0, ld1, clr, pix_ready;
    logic pix_valid, pix_sof, pix_eol, frame_done, ovf, err_len;
    logic [1:0] pix_data;
    logic [7:0] pix_x, pix_y;
    logic [$clog2(D):0] fill;

    always #5 clk = ~clk;

    dmg_lcd_capture #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D), .SYNC_STAGES(SS)) dut (
        .clk(clk), .n_res(n_res), .s(s), .cp(cp), .cpl(cpl), .st(st), .fr(fr),
        .ld0(ld0), .ld1(ld1), .clr(clr), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof),
        .pix_eol(pix_eol), .frame_done(frame_done), .ovf(ovf), .err_len(err_len),
        .fill(fill)
    );

    int   checks = 0;
    int   failures = 0;
    int   fd_count = 0;
    int   pop_count = 0;
    bit   rnd_ready = 1'b0;

    ent_t mq[$];
    int   mx = 0, my = 0, exp_frames = 0;
    bit   mact = 1'b0, msof = 1'b0, exp_err = 1'b0, exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: frame/line/pixel bookkeeping straight from the panel rules
    task automatic model(input bit es, input bit ep, input bit el, input logic [1:0] d);
        ent_t e;
        if (es) begin
            mx = 0; my = 0; msof = 1'b1; mact = 1'b1;
        end
        if (ep && mact) begin
            if (mx < W) begin
                e = '{d: d, x: 8'(mx), y: 8'(my), sof: msof, eol: (mx == W - 1)};
                if (mq.size() < D) mq.push_back(e);
                else exp_ovf = 1'b1;
                mx++;
                msof = 1'b0;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (el && mact) begin
            if (mx != W) exp_err = 1'b1;
            mx = 0;
            my++;
            if (my == H) begin
                exp_frames++;
                mact = 1'b0;
                my = 0;
            end
        end
    endtask

    task automatic monitor();
        ent_t e;
        if (frame_done === 1'b1) fd_count++;
        if (n_res && pix_valid === 1'b1 && pix_ready === 1'b1) begin
            checks++;
            assert (mq.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_pixel got x=%0d y=%0d exp none", pix_x, pix_y);
            end
            if (mq.size() != 0) begin
                e = mq.pop_front();
                chk("pix_head", {12'd0, pix_data, pix_x, pix_y, pix_sof, pix_eol}, {12'd0, e});
                pop_count++;
            end
        end
    endtask

    task automatic ticks(input int n, input bit frc);
        repeat (n) begin
            if (rnd_ready) pix_ready = frc ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            monitor();
            @(posedge clk);
            #2;
        end
    endtask

    task automatic lcd(input bit es, input bit ep, input bit el, input logic [1:0] d);
        ld1 = d[1];
        ld0 = d[0];
        ticks(2 + int'($urandom_range(0, 1)), 1'b0);
        if (es) s = 1'b1;
        if (ep) cp = 1'b0;
        if (el) cpl = 1'b1;
        model(es, ep, el, d);
        ticks(2 + int'($urandom_range(0, 1)), 1'b0);
        s = 1'b0;
        cp = 1'b1;
        cpl = 1'b0;
        ticks(2, 1'b1);
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) lcd(1'b0, 1'b1, 1'b0, 2'($urandom));
    endtask

    task automatic line_n(input int n);
        pixels(n);
        lcd(1'b0, 1'b0, 1'b1, 2'($urandom));
    endtask

    task automatic drain();
        int n = 0;
        rnd_ready = 1'b0;
        pix_ready = 1'b1;
        while (mq.size() != 0 && n < 200) begin
            ticks(1, 1'b1);
            n++;
        end
        checks++;
        assert (mq.size() == 0) else begin
            failures++;
            $error("FAIL drain_timeout got left=%0d exp 0", mq.size());
        end
        ticks(3, 1'b1);
        chk("fill_after_drain", 32'(fill), 0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        ticks(1, 1'b1);
        clr = 1'b0;
        exp_err = 1'b0;
        exp_ovf = 1'b0;
        ticks(1, 1'b1);
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, "_err_len"}, 32'(err_len), 32'(exp_err));
        chk({tag, "_frames"}, fd_count, exp_frames);
    endtask

    function automatic logic [31:0] all_outs();
        return {4'd0, pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
                frame_done, ovf, err_len, fill};
    endfunction

    initial begin
        n_res = 1'b0; s = 1'b0; cp = 1'b1; cpl = 1'b0; st = 1'b0; fr = 1'b0;
        ld0 = 1'b0; ld1 = 1'b0; clr = 1'b0; pix_ready = 1'b0;
        #23;
        chk("reset_state", all_outs(), 0);
        @(posedge clk);
        #2;
        n_res = 1'b1;
        ticks(4, 1'b1);

        // idle rejection
        rnd_ready = 1'b1;
        repeat (6) lcd(1'b0, 1'b1, 1'b0, 2'($urandom));
        lcd(1'b0, 1'b0, 1'b1, 2'($urandom));
        repeat (3) lcd(1'b0, 1'b1, 1'b1, 2'($urandom));
        chk("idle_fill", 32'(fill), 0);
        chk("idle_valid", 32'(pix_valid), 0);
        check_flags("idle");

        // full frame, data = x mod 4
        pop_count = 0;
        rnd_ready = 1'b1;
        lcd(1'b1, 1'b0, 1'b0, 2'd0);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) lcd(1'b0, 1'b1, 1'b0, 2'(x));
            lcd(1'b0, 1'b0, 1'b1, 2'd0);
        end
        drain();
        chk("frame_pixels", pop_count, W * H);
        check_flags("frame");

        // backpressure
        do_clr();
        rnd_ready = 1'b0;
        pix_ready = 1'b0;
        lcd(1'b1, 1'b0, 1'b0, 2'($urandom));
        pixels(20);
        ticks(4, 1'b0);
        chk("bp_fill", 32'(fill), D);
        chk("bp_ovf", 32'(ovf), 32'(exp_ovf));
        chk("bp_head", {13'd0, pix_valid, pix_x, pix_y, pix_sof}, {13'd0, 1'b1, 8'd0, 8'd0, 1'b1});
        drain();
        rnd_ready = 1'b1;
        pixels(W - 20);
        lcd(1'b0, 1'b0, 1'b1, 2'd0);
        drain();
        check_flags("bp_after");
        do_clr();
        chk("bp_clr_ovf", 32'(ovf), 0);

        // short and long lines
        rnd_ready = 1'b1;
        lcd(1'b1, 1'b0, 1'b0, 2'($urandom));
        line_n(W - 1);
        chk("short_err", 32'(err_len), 32'(exp_err));
        line_n(W);
        do_clr();
        chk("clr_err", 32'(err_len), 0);
        line_n(W + 1);
        chk("long_err", 32'(err_len), 32'(exp_err));
        do_clr();
        chk("clr_err2", 32'(err_len), 0);
        drain();

        // simultaneous events
        rnd_ready = 1'b1;
        lcd(1'b1, 1'b0, 1'b0, 2'($urandom));
        pixels(W - 1);
        lcd(1'b0, 1'b1, 1'b1, 2'($urandom));
        pixels(3);
        lcd(1'b1, 1'b1, 1'b0, 2'($urandom));
        pixels(3);
        drain();
        check_flags("simul");

        // mid-frame reset
        rnd_ready = 1'b1;
        lcd(1'b1, 1'b0, 1'b0, 2'($urandom));
        repeat (5) line_n(W);
        drain();
        pix_ready = 1'b0;
        pixels(5);
        ticks(3, 1'b0);
        chk("mid_fill", 32'(fill), 5);
        @(posedge clk);
        #3;
        n_res = 1'b0;
        #1;
        chk("mid_reset_outs", all_outs(), 0);
        mq.delete();
        mact = 1'b0; msof = 1'b0; mx = 0; my = 0;
        exp_err = 1'b0; exp_ovf = 1'b0;
        ticks(3, 1'b0);
        n_res = 1'b1;
        ticks(2, 1'b0);
        rnd_ready = 1'b1;
        pixels(5);
        lcd(1'b0, 1'b0, 1'b1, 2'($urandom));
        chk("post_reset_fill", 32'(fill), 0);
        lcd(1'b1, 1'b1, 1'b0, 2'($urandom));
        pixels(3);
        drain();
        check_flags("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmg_lcd_capture.md
# dmg_lcd_capture

Receiver for the DMG LCD panel interface on the front-board connector. It sits downstream of the DMG-CPU LCD pins (s, cp, cpl, st, ld0, ld1, fr) and converts the panel bus into a stream of 2-bit pixels tagged with (x, y), using a valid/ready handshake. It is used by board-level benches and the display model to capture frames. Inputs are oversampled with a system clock that is at least 4x the cp rate.

## Interface
Parameters:
- WIDTH, 160, pixels per line.
- HEIGHT, 144, lines per frame.
- FIFO_DEPTH, 8, output FIFO entries. Must be a power of 2, ≥2.
- SYNC_STAGES, 2, synchronizer flops per LCD input, ≥2.

Ports:
- clk  in  1  sampling clock. Rising edge active.
- n_res  in  1  reset. Asynchronous, active-low.
- s, cp, cpl, st, fr, ld0, ld1  in  1 each  raw LCD pins. st and fr are synchronized but unused.
- clr  in  1  one-cycle pulse that clears ovf and err_len.
- pix_valid  out  1  FIFO head is valid.
- pix_ready  in  1  consumer accepts the head.
- pix_data  out  2  {ld1, ld0} of the pixel.
- pix_x  out  8  column, 0..WIDTH-1.
- pix_y  out  8  row, 0..HEIGHT-1.
- pix_sof  out  1  head is pixel (0,0) of a frame.
- pix_eol  out  1  head is column WIDTH-1.
- frame_done  out  1  one-cycle pulse when the last line closes.
- ovf  out  1  sticky: a pixel was dropped because the FIFO was full.
- err_len  out  1  sticky: a line ended with a pixel count other than WIDTH, or an extra pixel arrived.
- fill  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Each LCD input passes through SYNC_STAGES flops. A further register holds the previous synchronized value for edge detection.
- Events are detected on synchronized signals:
  - s_rise: s rising edge.
  - pix: cp falling edge.
  - line: cpl rising edge.
- States:
  - IDLE: all pixels and lines ignored. Reset lands here.
  - ACTIVE: capture.
- s_rise in any state: x=0, y=0, set sof_pend, go to ACTIVE. A frame in progress is abandoned without setting err_len.
- pix in ACTIVE:
  - If x<WIDTH: build entry {data, x, y, sof=sof_pend, eol=(x==WIDTH-1)}, push it, x++, clear sof_pend.
  - If x≥WIDTH: drop the pixel, set err_len, x unchanged.
- line in ACTIVE:
  - If x≠WIDTH, set err_len.
  - Then x=0 and y++.
  - If the new y==HEIGHT: pulse frame_done, go to IDLE, y=0.
- Order within one cycle: s_rise, then pix, then line. Examples:
  - s_rise+pix: the pixel is (0,0) with sof=1.
  - pix+line: the pixel uses the pre-advance x and y.
- FIFO is first-word-fall-through: pix_* always shows the head entry.
  - Pop when pix_valid & pix_ready.
  - Push when fill<FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the entry is dropped and ovf is set. x still advances, so the coordinates of later pixels stay correct.
- fill tracks push minus pop. Push and pop together leave fill unchanged.
- Sticky flags:
  - clr clears ovf and err_len.
  - If clr coincides with a new error in the same cycle, the flag ends set.
- x and y are 8-bit, WIDTH,HEIGHT≤255. x saturates at WIDTH and does not wrap.

## Timing
- Reset values:
  - Outputs: pix_valid=0, pix_data/x/y/sof/eol=0, frame_done=0, ovf=0, err_len=0, fill=0.
  - Internal: state IDLE, sync chains 0, FIFO empty.
- Reset mid-frame discards FIFO contents immediately (asynchronously). Capture restarts only at the next s_rise.
- Pixel latency: let edge 1 be the first clk edge that samples cp low. The push happens on edge SYNC_STAGES+1. With an empty FIFO, pix_valid is high after that edge.
- frame_done and the IDLE transition happen on edge SYNC_STAGES+1 after the first edge that samples cpl high.
- Input requirement: each level of cp, cpl and s must be held ≥2 clk periods. ld0 and ld1 must be stable from SYNC_STAGES periods before the cp fall until 1 period after it. Violations are not detected.
- pix_valid never deasserts without a pop. pix_* stay stable while pix_valid & !pix_ready.

## Test plan
- **Reset then full frame:** s pulse, then 144 lines of 160 cp falls each. ld1:ld0 = x[1:0] on all rows. pix_ready=1. Required: 23040 pixels in order; pix_data=x%4; sof only on (0,0); eol on x=159; one frame_done; ovf=err_len=0.
- **Backpressure:** pix_ready=0 for 20 pixels with FIFO_DEPTH=8. Required: fill=8, ovf=1, head stays (0,0). Release: 8 entries drain, then the next pixel appears with x=20 (x kept advancing).
- **Short and long lines:** a line of 159 pixels, then cpl. Required: err_len=1, next line y=1 x=0. Then a line of 161 pixels. Required: 161st pixel dropped. clr pulse: err_len=0.
- **Simultaneous events:** cp fall and cpl rise in the same clk. Required: the pixel carries the old y with x=159, then y increments. s rise with cp fall: pixel (0,0), sof=1.
- **Mid-frame reset:** n_res low during line 50 with fill=5. Required: all outputs 0 immediately. Pixels before the next s are ignored; capture resumes at (0,0).
- **Idle rejection:** cp and cpl activity after reset with no s. Required: no pushes, fill=0, no frame_done, err_len=0.
